load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Executes the data-memory side of the control word decoded per instruction: consumes MemRead/MemWrite
//  (3'b100 = access enabled, 3'b000 = none), funct3 and the ALU-computed address. Runs one RV64 load or
//  store per request over a req/gnt/rvalid data-memory port, stalls the pipeline meanwhile, and returns
//  sign/zero-extended load data to writeback. Sits between EX and WB, beside the register file write port.
// PARAMETERS
//  XLEN    64  datapath / register width
//  ADDR_W  32  data-memory byte-address width
// PORTS
//  clk          in   1       core clock
//  rst_n        in   1       asynchronous active-low reset
//  ex_valid     in   1       EX stage presents a valid instruction this cycle
//  mem_read     in   3       load enable from control decode (nonzero = load)
//  mem_write    in   3       store enable from control decode (nonzero = store)
//  funct3       in   3       access size/sign: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  rd_in        in   5       load destination register
//  addr         in   XLEN    effective byte address (low ADDR_W bits used)
//  store_data   in   XLEN    rs2 value for stores
//  stall        out  1       hold PC/IF/ID/EX
//  wb_valid     out  1       one-cycle pulse: wb_data valid for wb_rd
//  wb_rd        out  5       destination register of completing load
//  wb_data      out  XLEN    extended load result
//  lsu_err      out  1       one-cycle pulse: misaligned or illegal access, no memory traffic issued
//  dmem_req     out  1       memory request
//  dmem_we      out  1       1 = write
//  dmem_addr    out  ADDR_W  doubleword-aligned address (addr[2:0] = 0)
//  dmem_be      out  8       byte enables
//  dmem_wdata   out  64      lane-shifted store data
//  dmem_gnt     in   1       request accepted this cycle
//  dmem_rvalid  in   1       read data valid this cycle
//  dmem_rdata   in   64      read doubleword
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; stall, wb_valid, lsu_err, dmem_req, dmem_we = 0; wb_rd, wb_data,
//    dmem_addr, dmem_be, dmem_wdata = 0. dmem_req drops immediately; in-flight rvalid after reset ignored.
//  - FSM IDLE -> REQ -> (load: WAIT) -> RESP -> IDLE. All dmem_* and wb_* outputs registered.
//  - IDLE: accept when ex_valid & (mem_read|mem_write != 0). Error if both nonzero, load funct3=111,
//    store funct3[2]=1, or addr not aligned to size (H:a[0]=0, W:a[1:0]=0, D:a[2:0]=0) -> lsu_err=1 next
//    cycle, stay IDLE, no request. Valid op: latch op/size/rd/lanes, go REQ.
//  - stall = (IDLE & valid accept) | REQ | WAIT; stall=0 in RESP so pipeline advances that cycle.
//  - REQ: dmem_req=1; addr/be/we/wdata held stable until dmem_gnt. On gnt: store -> RESP, load -> WAIT.
//  - WAIT: on dmem_rvalid, select lanes at addr[2:0], sign-extend (B/H/W/D) or zero-extend (BU/HU/WU),
//    register wb_data -> RESP. rvalid coincident with gnt (same cycle) is not allowed by memory protocol.
//  - RESP: load: wb_valid=1, wb_rd=latched rd (rd=0 still pulses; regfile ignores x0). Store: wb_valid=0.
//    -> IDLE; a new op may be accepted the following cycle (min 1 idle cycle between ops).
//  - Byte enables: B 8'b1<<a, H 8'b11<<a, W 8'hF<<a, D 8'hFF; wdata = store_data[size-1:0] << (8*a).
//  - Min latency (gnt in first REQ cycle, rvalid next): load wb_valid 3 cycles after accept; store 2.
//  - No timeout; unbounded gnt/rvalid wait keeps stall high.
// STRUCTURE
//  - Shared header riscv_defs.vh: opcode/funct3 size codes, MEM_EN=3'b100, LSU state encodings.
//  - Sub-module lsu_align (combinational): size+offset -> dmem_be, shifted wdata, extracted+extended rdata.
//  - Top holds FSM, latches, handshake registers.
// TESTING
//  1. LD addr=0x1000, gnt+rvalid immediate, rdata=0x1122334455667788 -> wb_data same, wb_rd=rd, 3-cycle lat.
//  2. LB addr=0x1003, rdata byte3=0x80 -> wb_data=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80; dmem_be=8'h08.
//  3. SH addr=0x2006, data=0xBEEF -> dmem_be=8'hC0, wdata[63:48]=0xBEEF, we=1; no wb_valid.
//  4. LW addr=0x1002 -> lsu_err pulse, dmem_req never asserts, stall=0; mem_read&mem_write both set -> err.
//  5. gnt held low 5 cycles -> req/addr/be stable, stall high throughout; rvalid delayed 4 more -> still stalls.
//  6. rst_n low during WAIT -> all outputs 0 asynchronously; late rvalid after release produces no wb_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 size/sign
// codes and the natural-alignment check used when an access is accepted.
package load_store_unit_pkg;

  // Access size, taken from funct3[1:0]
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // funct3 codes that need distinct load extension
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // An access must sit on a multiple of its own size inside the doubleword.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic r;
    case (size)
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      SZ_D:    r = |off;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering for the load/store unit.
// Store side: size + byte offset -> byte enables and lane-shifted write data.
// Load side : funct3 + byte offset + read doubleword -> extracted, extended value.
//  st_size    in   2   access size (funct3[1:0])
//  st_offset  in   3   byte offset within the doubleword
//  st_data    in   64  unshifted store data (rs2)
//  st_be      out  8   byte enables
//  st_wdata   out  64  store data moved to its byte lanes, unused lanes zero
//  ld_funct3  in   3   load size/sign code
//  ld_offset  in   3   byte offset of the load
//  ld_rdata   in   64  doubleword returned by memory
//  ld_data    out  64  sign- or zero-extended load result
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [2:0]  st_offset,
  input  logic [63:0] st_data,
  output logic [7:0]  st_be,
  output logic [63:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [2:0]  ld_offset,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data
);

  logic [63:0] st_mask;
  logic [63:0] ld_lane;

  always_comb begin
    st_mask = 64'h0000_0000_0000_00FF;
    st_be   = 8'h01 << st_offset;
    case (st_size)
      SZ_H: begin
        st_mask = 64'h0000_0000_0000_FFFF;
        st_be   = 8'h03 << st_offset;
      end
      SZ_W: begin
        st_mask = 64'h0000_0000_FFFF_FFFF;
        st_be   = 8'h0F << st_offset;
      end
      SZ_D: begin
        st_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        st_be   = 8'hFF;
      end
      default: ;
    endcase
    st_wdata = (st_data & st_mask) << {st_offset, 3'b000};
  end

  always_comb begin
    // Bring the addressed byte down to lane 0, then extend from the access width.
    ld_lane = ld_rdata >> {ld_offset, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{56{ld_lane[7]}},  ld_lane[7:0]};
      F3_H:    ld_data = {{48{ld_lane[15]}}, ld_lane[15:0]};
      F3_W:    ld_data = {{32{ld_lane[31]}}, ld_lane[31:0]};
      F3_BU:   ld_data = {56'd0, ld_lane[7:0]};
      F3_HU:   ld_data = {48'd0, ld_lane[15:0]};
      F3_WU:   ld_data = {32'd0, ld_lane[31:0]};
      default: ld_data = ld_lane;  // doubleword
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit between EX and WB. Accepts one memory op from EX,
// checks it for legality/alignment, runs it over a req/gnt/rvalid data-memory
// port while stalling the front of the pipeline, and hands the extended load
// result to writeback as a one-cycle pulse.
//  clk, rst_n                  clock, asynchronous active-low reset
//  ex_valid, mem_read,
//  mem_write, funct3, rd_in,
//  addr, store_data            operation presented by EX
//  stall                       hold PC/IF/ID/EX
//  wb_valid, wb_rd, wb_data    load completion to the register file
//  lsu_err                     pulse for a rejected (illegal/misaligned) op
//  dmem_*                      data-memory request/response port
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [2:0]        mem_read,
  input  logic [2:0]        mem_write,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_in,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              lsu_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_be,
  output logic [63:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [63:0]       dmem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        offset_q, offset_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              lsu_err_q, lsu_err_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [7:0]        dmem_be_q, dmem_be_d;
  logic [63:0]       dmem_wdata_q, dmem_wdata_d;

  logic        is_rd, is_wr, access, bad_op, ok_op;
  logic [7:0]  new_be;
  logic [63:0] new_wdata;
  logic [63:0] ld_data;
  logic        unused_addr_bits;

  // Only the low ADDR_W address bits reach the memory port.
  assign unused_addr_bits = ^addr[XLEN-1:ADDR_W];

  assign is_rd  = |mem_read;
  assign is_wr  = |mem_write;
  assign access = ex_valid & (is_rd | is_wr);
  assign bad_op = (is_rd & is_wr)
                | (is_rd & (funct3 == F3_ILL))
                | (is_wr & funct3[2])
                | misaligned(funct3[1:0], addr[2:0]);
  assign ok_op  = access & ~bad_op;

  // Combinational so EX is frozen in the very cycle the op is accepted;
  // RESP releases the pipeline so the next instruction moves up.
  assign stall = ((state_q == ST_IDLE) & ok_op)
               | (state_q == ST_REQ)
               | (state_q == ST_WAIT);

  // Store lanes come from the incoming op; load lanes from the latched op.
  load_store_unit_align u_align (
    .st_size   (funct3[1:0]),
    .st_offset (addr[2:0]),
    .st_data   (store_data[63:0]),
    .st_be     (new_be),
    .st_wdata  (new_wdata),
    .ld_funct3 (funct3_q),
    .ld_offset (offset_q),
    .ld_rdata  (dmem_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    rd_d         = rd_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    lsu_err_d    = 1'b0;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (bad_op) begin
            lsu_err_d = 1'b1;
          end else begin
            state_d      = ST_REQ;
            is_load_d    = is_rd;
            funct3_d     = funct3;
            offset_d     = addr[2:0];
            rd_d         = rd_in;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_wr;
            dmem_addr_d  = {addr[ADDR_W-1:3], 3'b000};
            dmem_be_d    = new_be;
            dmem_wdata_d = new_wdata;
          end
        end
      end
      ST_REQ: begin
        // Request fields stay frozen until memory accepts them.
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          state_d    = is_load_q ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          wb_data_d  = ld_data;
          wb_rd_d    = rd_q;
          wb_valid_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      default: begin  // ST_RESP: wb_valid is high for exactly this cycle
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 3'd0;
      rd_q         <= 5'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      lsu_err_q    <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= 8'd0;
      dmem_wdata_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      rd_q         <= rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      lsu_err_q    <= lsu_err_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign lsu_err    = lsu_err_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level
// reference model of RV64 load/store semantics.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  mem_read, mem_write, funct3;
  logic [4:0]  rd_in;
  logic [63:0] addr, store_data;
  logic        stall, wb_valid, lsu_err, dmem_req, dmem_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .rd_in(rd_in), .addr(addr),
    .store_data(store_data), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .lsu_err(lsu_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (byte-level) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_err(input logic ld, input logic st, input logic [2:0] f3,
                                     input int off);
    if (ld && st) return 1'b1;
    if (ld && f3 == 3'd7) return 1'b1;
    if (st && f3 >= 3'd4) return 1'b1;
    return (off % nbytes(f3)) != 0;
  endfunction

  function automatic logic [7:0] model_be(input logic [2:0] f3, input int off);
    logic [7:0] be;
    for (int i = 0; i < 8; i++) be[i] = (i >= off) && (i < off + nbytes(f3));
    return be;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [2:0] f3, input int off,
                                              input logic [63:0] sd);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < nbytes(f3); i++) w[8*(off+i) +: 8] = sd[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [63:0] rdat);
    logic [63:0] v = 64'd0;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
    if (f3 < 3'd4 && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One operation from EX through to completion, checked cycle by cycle.
  // gd = cycles gnt is withheld, rdd = cycles rvalid is withheld after gnt.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [63:0] a, input logic [63:0] sd,
                        input logic [63:0] rdat, input int gd, input int rdd);
    int          off = int'(a[2:0]);
    logic        e   = model_err(ld, st, f3, off);
    logic [63:0] exp_addr = {32'd0, a[31:3], 3'b000};
    @(negedge clk);
    ex_valid = 1'b1; mem_read = ld ? 3'b100 : 3'b000; mem_write = st ? 3'b100 : 3'b000;
    funct3 = f3; rd_in = rd; addr = a; store_data = sd;
    #1 check({tag, " stall@accept"}, 64'(stall), 64'(!e));
    @(negedge clk);
    // Scramble the EX inputs so anything not latched shows up as an error.
    ex_valid = 1'b0; mem_read = 3'b000; mem_write = 3'b000;
    funct3 = 3'($urandom); rd_in = 5'($urandom); addr = {$urandom, $urandom};
    store_data = {$urandom, $urandom};
    if (e) begin
      check({tag, " lsu_err"}, 64'(lsu_err), 64'd1);
      check({tag, " no req"}, 64'(dmem_req), 64'd0);
      check({tag, " stall err"}, 64'(stall), 64'd0);
      @(negedge clk);
      check({tag, " lsu_err pulse"}, 64'(lsu_err), 64'd0);
      check({tag, " still no req"}, 64'(dmem_req), 64'd0);
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      check({tag, " req"}, 64'(dmem_req), 64'd1);
      check({tag, " addr"}, 64'(dmem_addr), exp_addr);
      check({tag, " be"}, 64'(dmem_be), 64'(model_be(f3, off)));
      check({tag, " we"}, 64'(dmem_we), 64'(st));
      if (st) check({tag, " wdata"}, dmem_wdata, model_wdata(f3, off, sd));
      check({tag, " stall req"}, 64'(stall), 64'd1);
      check({tag, " lsu_err req"}, 64'(lsu_err), 64'd0);
      dmem_gnt = (k == gd);
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    if (ld) begin
      for (int k = 0; k <= rdd; k++) begin
        check({tag, " stall wait"}, 64'(stall), 64'd1);
        check({tag, " req off"}, 64'(dmem_req), 64'd0);
        check({tag, " wb_valid wait"}, 64'(wb_valid), 64'd0);
        dmem_rvalid = (k == rdd);
        dmem_rdata  = (k == rdd) ? rdat : {$urandom, $urandom};
        @(negedge clk);
      end
      dmem_rvalid = 1'b0;
    end
    check({tag, " stall resp"}, 64'(stall), 64'd0);
    check({tag, " wb_valid resp"}, 64'(wb_valid), 64'(ld));
    check({tag, " req resp"}, 64'(dmem_req), 64'd0);
    if (ld) begin
      check({tag, " wb_data"}, wb_data, model_load(f3, off, rdat));
      check({tag, " wb_rd"}, 64'(wb_rd), 64'(rd));
    end
    @(negedge clk);
    check({tag, " wb_valid pulse"}, 64'(wb_valid), 64'd0);
    check({tag, " idle stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 3'b000; mem_write = 3'b000; funct3 = 3'b000;
    rd_in = 5'd0; addr = 64'd0; store_data = 64'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;

    // Reset state
    @(negedge clk);
    check("rst stall", 64'(stall), 64'd0);
    check("rst wb_valid", 64'(wb_valid), 64'd0);
    check("rst lsu_err", 64'(lsu_err), 64'd0);
    check("rst req", 64'(dmem_req), 64'd0);
    check("rst we", 64'(dmem_we), 64'd0);
    check("rst wb_data", wb_data, 64'd0);
    check("rst addr", 64'(dmem_addr), 64'd0);
    check("rst be", 64'(dmem_be), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op("LD", 1, 0, 3'b011, 5'd10, 64'h1000, 64'd0, 64'h1122334455667788, 0, 0);
    run_op("LB", 1, 0, 3'b000, 5'd3, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    run_op("LBU", 1, 0, 3'b100, 5'd4, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    run_op("SH", 0, 1, 3'b001, 5'd7, 64'h2006, 64'h1234_5678_9ABC_BEEF, 64'd0, 0, 0);
    run_op("LW misaligned", 1, 0, 3'b010, 5'd5, 64'h1002, 64'd0, 64'd0, 0, 0);
    run_op("rd+wr", 1, 1, 3'b011, 5'd5, 64'h1000, 64'd0, 64'd0, 0, 0);
    run_op("load f3=7", 1, 0, 3'b111, 5'd5, 64'h1000, 64'd0, 64'd0, 0, 0);
    run_op("store f3=4", 0, 1, 3'b100, 5'd5, 64'h1000, 64'd0, 64'd0, 0, 0);
    run_op("LD slow", 1, 0, 3'b011, 5'd9, 64'h3008, 64'd0, 64'hCAFE_F00D_1357_2468, 5, 4);
    run_op("SD slow", 0, 1, 3'b011, 5'd9, 64'h3010, 64'hDEAD_BEEF_0BAD_F00D, 64'd0, 5, 0);
    run_op("LHU x0", 1, 0, 3'b101, 5'd0, 64'h4002, 64'd0, 64'h0000_0000_F00D_0000, 1, 1);
    run_op("LWU", 1, 0, 3'b110, 5'd6, 64'h4004, 64'd0, 64'h8765_4321_0000_0000, 0, 2);

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [2:0]  m;
      ld = 1'($urandom_range(0, 1));
      st = !ld;
      if ($urandom_range(0, 9) == 0) begin ld = 1'b1; st = 1'b1; end
      f3 = 3'($urandom_range(0, 7));
      a  = {32'd0, $urandom};
      m  = 3'(nbytes(f3) - 1);
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~m;
      run_op("rand", ld, st, f3, 5'($urandom), a, {$urandom, $urandom},
             {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in WAIT, then a late rvalid that must be ignored
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 3'b100; funct3 = 3'b010; rd_in = 5'd12; addr = 64'h5004;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 3'b000; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("pre-rst stall", 64'(stall), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst stall", 64'(stall), 64'd0);
    check("arst req", 64'(dmem_req), 64'd0);
    check("arst we", 64'(dmem_we), 64'd0);
    check("arst addr", 64'(dmem_addr), 64'd0);
    check("arst be", 64'(dmem_be), 64'd0);
    check("arst wdata", dmem_wdata, 64'd0);
    check("arst wb_valid", 64'(wb_valid), 64'd0);
    check("arst wb_rd", 64'(wb_rd), 64'd0);
    check("arst wb_data", wb_data, 64'd0);
    check("arst lsu_err", 64'(lsu_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late rvalid wb_valid", 64'(wb_valid), 64'd0);
    check("late rvalid stall", 64'(stall), 64'd0);
    @(negedge clk);
    check("late rvalid wb_valid2", 64'(wb_valid), 64'd0);
    check("late rvalid req", 64'(dmem_req), 64'd0);

    // Unit still works after reset
    run_op("LD post-rst", 1, 0, 3'b011, 5'd1, 64'h6000, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
